// File: rtl/mapache64.sv
// Shared Mapache64 VRAM definitions: region enum, region address map and the
// bit order of the one-hot VRAM region select.
package mapache64;

  typedef enum logic [2:0] {
    REGION_PMF,
    REGION_PMB,
    REGION_NTBL,
    REGION_OBM,
    REGION_TXBL,
    REGION_INVALID
  } region_t;

  localparam logic [11:0] PMF_BASE   = 12'h000;
  localparam logic [11:0] PMF_LIMIT  = 12'h1FF;
  localparam logic [11:0] PMB_BASE   = 12'h200;
  localparam logic [11:0] PMB_LIMIT  = 12'h3FF;
  localparam logic [11:0] NTBL_BASE  = 12'h400;
  localparam logic [11:0] NTBL_LIMIT = 12'h7FF;
  localparam logic [11:0] OBM_BASE   = 12'h800;
  localparam logic [11:0] OBM_LIMIT  = 12'h8FF;
  localparam logic [11:0] TXBL_BASE  = 12'h900;
  localparam logic [11:0] TXBL_LIMIT = 12'hCFF;

  // select_o is {txbl, obm, ntbl, pmb, pmf}
  localparam int SEL_PMF  = 0;
  localparam int SEL_PMB  = 1;
  localparam int SEL_NTBL = 2;
  localparam int SEL_OBM  = 3;
  localparam int SEL_TXBL = 4;

  function automatic region_t decode_region(input logic [11:0] addr);
    if (addr <= PMF_LIMIT)       return REGION_PMF;
    else if (addr <= PMB_LIMIT)  return REGION_PMB;
    else if (addr <= NTBL_LIMIT) return REGION_NTBL;
    else if (addr <= OBM_LIMIT)  return REGION_OBM;
    else if (addr <= TXBL_LIMIT) return REGION_TXBL;
    else                         return REGION_INVALID;
  endfunction

  function automatic logic [11:0] region_base(input region_t region);
    case (region)
      REGION_PMB:  return PMB_BASE;
      REGION_NTBL: return NTBL_BASE;
      REGION_OBM:  return OBM_BASE;
      REGION_TXBL: return TXBL_BASE;
      default:     return PMF_BASE;
    endcase
  endfunction

  function automatic logic [4:0] region_select(input region_t region);
    logic [4:0] sel;
    sel = '0;
    case (region)
      REGION_PMF:  sel[SEL_PMF]  = 1'b1;
      REGION_PMB:  sel[SEL_PMB]  = 1'b1;
      REGION_NTBL: sel[SEL_NTBL] = 1'b1;
      REGION_OBM:  sel[SEL_OBM]  = 1'b1;
      REGION_TXBL: sel[SEL_TXBL] = 1'b1;
      default:     sel = '0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/vram_write_fifo.sv
// Synchronous write queue holding {address, data} entries for the VRAM write
// scheduler; head entry is visible on rd_data whenever the queue is non-empty.
module vram_write_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/vram_write_scheduler.sv
// Queues CPU VRAM writes and commits them in order when the GPU is not using
// the target region. Define VRAM_SCHED_OVERFLOW_EN for a sticky drop flag.
module vram_write_scheduler
  import mapache64::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          gpu_clk,
  input  logic                          rst,
  input  logic                          wr_valid_i,
  input  logic [11:0]                   wr_address_i,
  input  logic [7:0]                    wr_data_i,
  output logic                          wr_ready_o,
  input  logic                          in_vblank_i,
  input  logic                          drawing_next_i,
  output logic                          vram_wen_o,
  output logic [10:0]                   vram_offset_o,
  output logic [7:0]                    vram_data_o,
  output logic [4:0]                    select_o,
  output logic [$clog2(FIFO_DEPTH):0]   pending_o,
  input  logic                          clr_overflow_i,
  output logic                          overflow_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, WAIT, COMMIT} state_t;

  state_t         state, state_next;
  logic [19:0]    head;
  logic [11:0]    head_addr;
  logic [7:0]     head_data;
  logic           fifo_full, fifo_empty;
  logic [CW-1:0]  count, count_next;
  logic           push, pop, commit, window_open;
  region_t        head_region;

  assign wr_ready_o  = !fifo_full;
  assign push        = wr_valid_i && !fifo_full;
  assign head_addr   = head[19:8];
  assign head_data   = head[7:0];
  assign head_region = decode_region(head_addr);
  assign count_next  = count + CW'(push) - CW'(pop);
  assign pending_o   = count;

  vram_write_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(20)) u_fifo (
    .clk     (gpu_clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data ({wr_address_i, wr_data_i}),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  // OBM is scanned all frame long, so it is only safe during vblank.
  always_comb begin
    window_open = 1'b0;
    case (head_region)
      REGION_OBM:     window_open = in_vblank_i;
      REGION_INVALID: window_open = 1'b0;
      default:        window_open = !drawing_next_i;
    endcase
  end

  always_comb begin
    pop        = 1'b0;
    commit     = 1'b0;
    state_next = state;
    case (state)
      IDLE, WAIT: begin
        if (!fifo_empty) begin
          if (head_region == REGION_INVALID) begin
            pop = 1'b1;
          end else if (window_open) begin
            pop    = 1'b1;
            commit = 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (commit)                state_next = COMMIT;
    else if (count_next != '0) state_next = WAIT;
    else                       state_next = IDLE;
  end

  always_ff @(posedge gpu_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Offset and data hold their last committed values; select only pulses.
  always_ff @(posedge gpu_clk) begin
    if (rst) begin
      vram_wen_o    <= 1'b0;
      vram_offset_o <= '0;
      vram_data_o   <= '0;
      select_o      <= '0;
    end else begin
      vram_wen_o <= commit;
      if (commit) begin
        vram_offset_o <= 11'(head_addr - region_base(head_region));
        vram_data_o   <= head_data;
        select_o      <= region_select(head_region);
      end else begin
        select_o      <= '0;
      end
    end
  end

`ifdef VRAM_SCHED_OVERFLOW_EN
  always_ff @(posedge gpu_clk) begin
    if (rst)                            overflow_o <= 1'b0;
    else if (wr_valid_i && fifo_full)   overflow_o <= 1'b1;
    else if (clr_overflow_i)            overflow_o <= 1'b0;
  end
`else
  logic unused_clr;
  assign unused_clr = clr_overflow_i;
  assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Directed self-checking bench for vram_write_scheduler (FIFO_DEPTH = 8).
module tb_vram_write_scheduler;

  logic        gpu_clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid_i = 1'b0;
  logic [11:0] wr_address_i = '0;
  logic [7:0]  wr_data_i = '0;
  logic        wr_ready_o;
  logic        in_vblank_i = 1'b0;
  logic        drawing_next_i = 1'b0;
  logic        vram_wen_o;
  logic [10:0] vram_offset_o;
  logic [7:0]  vram_data_o;
  logic [4:0]  select_o;
  logic [3:0]  pending_o;
  logic        clr_overflow_i = 1'b0;
  logic        overflow_o;

  int n_checks = 0;
  int n_fail = 0;

`ifdef VRAM_SCHED_OVERFLOW_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  vram_write_scheduler #(.FIFO_DEPTH(8)) dut (
    .gpu_clk        (gpu_clk),
    .rst            (rst),
    .wr_valid_i     (wr_valid_i),
    .wr_address_i   (wr_address_i),
    .wr_data_i      (wr_data_i),
    .wr_ready_o     (wr_ready_o),
    .in_vblank_i    (in_vblank_i),
    .drawing_next_i (drawing_next_i),
    .vram_wen_o     (vram_wen_o),
    .vram_offset_o  (vram_offset_o),
    .vram_data_o    (vram_data_o),
    .select_o       (select_o),
    .pending_o      (pending_o),
    .clr_overflow_i (clr_overflow_i),
    .overflow_o     (overflow_o)
  );

  always #5 gpu_clk = ~gpu_clk;

  task automatic tick();
    @(posedge gpu_clk);
    #1;
  endtask

  task automatic do_write(input logic [11:0] addr, input logic [7:0] data);
    wr_valid_i   = 1'b1;
    wr_address_i = addr;
    wr_data_i    = data;
    tick();
    wr_valid_i   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++; if (vram_wen_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wen got %0b exp 0", vram_wen_o); end
    n_checks++; if (select_o !== 5'b0) begin n_fail++; $display("[TB] FAIL reset_sel got %b exp 00000", select_o); end
    n_checks++; if (vram_offset_o !== 11'h0) begin n_fail++; $display("[TB] FAIL reset_offset got %h exp 000", vram_offset_o); end
    n_checks++; if (vram_data_o !== 8'h0) begin n_fail++; $display("[TB] FAIL reset_data got %h exp 00", vram_data_o); end
    n_checks++; if (pending_o !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_pending got %0d exp 0", pending_o); end
    n_checks++; if (wr_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready got %0b exp 1", wr_ready_o); end
    n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_overflow got %0b exp 0", overflow_o); end
  endtask

  task automatic test_txbl_latency();
    drawing_next_i = 1'b0;
    in_vblank_i    = 1'b0;
    do_write(12'h905, 8'h41);
    n_checks++; if (vram_wen_o !== 1'b0) begin n_fail++; $display("[TB] FAIL txbl_wen_n1 got %0b exp 0", vram_wen_o); end
    n_checks++; if (pending_o !== 4'd1) begin n_fail++; $display("[TB] FAIL txbl_pending got %0d exp 1", pending_o); end
    tick();
    n_checks++; if (vram_wen_o !== 1'b1) begin n_fail++; $display("[TB] FAIL txbl_wen_n2 got %0b exp 1", vram_wen_o); end
    n_checks++; if (select_o !== 5'b10000) begin n_fail++; $display("[TB] FAIL txbl_sel got %b exp 10000", select_o); end
    n_checks++; if (vram_offset_o !== 11'h005) begin n_fail++; $display("[TB] FAIL txbl_offset got %h exp 005", vram_offset_o); end
    n_checks++; if (vram_data_o !== 8'h41) begin n_fail++; $display("[TB] FAIL txbl_data got %h exp 41", vram_data_o); end
    tick();
    n_checks++; if (vram_wen_o !== 1'b0) begin n_fail++; $display("[TB] FAIL txbl_wen_n3 got %0b exp 0", vram_wen_o); end
    n_checks++; if (select_o !== 5'b0) begin n_fail++; $display("[TB] FAIL txbl_sel_idle got %b exp 00000", select_o); end
    n_checks++; if (vram_offset_o !== 11'h005) begin n_fail++; $display("[TB] FAIL txbl_offset_hold got %h exp 005", vram_offset_o); end
    n_checks++; if (vram_data_o !== 8'h41) begin n_fail++; $display("[TB] FAIL txbl_data_hold got %h exp 41", vram_data_o); end
  endtask

  task automatic test_obm_vblank();
    drawing_next_i = 1'b0;
    in_vblank_i    = 1'b0;
    do_write(12'h810, 8'h7F);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (vram_wen_o !== 1'b0) begin n_fail++; $display("[TB] FAIL obm_blocked_wen cycle %0d got %0b exp 0", i, vram_wen_o); end
    end
    in_vblank_i = 1'b1;
    tick();
    n_checks++; if (vram_wen_o !== 1'b1) begin n_fail++; $display("[TB] FAIL obm_wen got %0b exp 1", vram_wen_o); end
    n_checks++; if (select_o !== 5'b01000) begin n_fail++; $display("[TB] FAIL obm_sel got %b exp 01000", select_o); end
    n_checks++; if (vram_offset_o !== 11'h010) begin n_fail++; $display("[TB] FAIL obm_offset got %h exp 010", vram_offset_o); end
    n_checks++; if (vram_data_o !== 8'h7F) begin n_fail++; $display("[TB] FAIL obm_data got %h exp 7f", vram_data_o); end
    in_vblank_i = 1'b0;
    tick();
  endtask

  task automatic test_order_blocking();
    drawing_next_i = 1'b0;
    in_vblank_i    = 1'b0;
    do_write(12'h820, 8'hAA);
    do_write(12'h000, 8'h55);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (vram_wen_o !== 1'b0) begin n_fail++; $display("[TB] FAIL order_blocked_wen cycle %0d got %0b exp 0", i, vram_wen_o); end
      n_checks++; if (pending_o !== 4'd2) begin n_fail++; $display("[TB] FAIL order_pending cycle %0d got %0d exp 2", i, pending_o); end
    end
    in_vblank_i = 1'b1;
    tick();
    n_checks++; if (select_o !== 5'b01000) begin n_fail++; $display("[TB] FAIL order_first_sel got %b exp 01000", select_o); end
    n_checks++; if (vram_data_o !== 8'hAA) begin n_fail++; $display("[TB] FAIL order_first_data got %h exp aa", vram_data_o); end
    tick();
    n_checks++; if (vram_wen_o !== 1'b0) begin n_fail++; $display("[TB] FAIL order_gap_wen got %0b exp 0", vram_wen_o); end
    tick();
    n_checks++; if (vram_wen_o !== 1'b1) begin n_fail++; $display("[TB] FAIL order_second_wen got %0b exp 1", vram_wen_o); end
    n_checks++; if (select_o !== 5'b00001) begin n_fail++; $display("[TB] FAIL order_second_sel got %b exp 00001", select_o); end
    n_checks++; if (vram_data_o !== 8'h55) begin n_fail++; $display("[TB] FAIL order_second_data got %h exp 55", vram_data_o); end
    n_checks++; if (pending_o !== 4'd0) begin n_fail++; $display("[TB] FAIL order_pending_end got %0d exp 0", pending_o); end
    in_vblank_i = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    int got;
    drawing_next_i = 1'b1;
    in_vblank_i    = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wr_valid_i   = 1'b1;
      wr_address_i = 12'(i);
      wr_data_i    = 8'(8'h10 + i);
      tick();
    end
    wr_valid_i = 1'b0;
    n_checks++; if (wr_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_ready got %0b exp 0", wr_ready_o); end
    n_checks++; if (pending_o !== 4'd8) begin n_fail++; $display("[TB] FAIL ovf_pending got %0d exp 8", pending_o); end
    n_checks++; if (overflow_o !== OVF_EXP) begin n_fail++; $display("[TB] FAIL ovf_flag got %0b exp %0b", overflow_o, OVF_EXP); end
    clr_overflow_i = 1'b1;
    tick();
    clr_overflow_i = 1'b0;
    n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_clear got %0b exp 0", overflow_o); end
    drawing_next_i = 1'b0;
    got = 0;
    for (int c = 0; c < 24; c++) begin
      tick();
      if (vram_wen_o === 1'b1) begin
        n_checks++; if (vram_data_o !== 8'(8'h10 + got)) begin n_fail++; $display("[TB] FAIL drain_data idx %0d got %h exp %h", got, vram_data_o, 8'(8'h10 + got)); end
        n_checks++; if (vram_offset_o !== 11'(got)) begin n_fail++; $display("[TB] FAIL drain_offset idx %0d got %h exp %h", got, vram_offset_o, 11'(got)); end
        got++;
      end
    end
    n_checks++; if (got !== 8) begin n_fail++; $display("[TB] FAIL drain_count got %0d exp 8", got); end
    n_checks++; if (pending_o !== 4'd0) begin n_fail++; $display("[TB] FAIL drain_pending got %0d exp 0", pending_o); end
    n_checks++; if (wr_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL drain_ready got %0b exp 1", wr_ready_o); end
  endtask

  task automatic test_invalid_region();
    drawing_next_i = 1'b0;
    in_vblank_i    = 1'b0;
    do_write(12'hE00, 8'h99);
    n_checks++; if (vram_wen_o !== 1'b0) begin n_fail++; $display("[TB] FAIL inv_wen_a got %0b exp 0", vram_wen_o); end
    do_write(12'h400, 8'h12);
    n_checks++; if (vram_wen_o !== 1'b0) begin n_fail++; $display("[TB] FAIL inv_wen_b got %0b exp 0", vram_wen_o); end
    n_checks++; if (pending_o !== 4'd1) begin n_fail++; $display("[TB] FAIL inv_pending got %0d exp 1", pending_o); end
    tick();
    n_checks++; if (vram_wen_o !== 1'b1) begin n_fail++; $display("[TB] FAIL ntbl_wen got %0b exp 1", vram_wen_o); end
    n_checks++; if (select_o !== 5'b00100) begin n_fail++; $display("[TB] FAIL ntbl_sel got %b exp 00100", select_o); end
    n_checks++; if (vram_offset_o !== 11'h000) begin n_fail++; $display("[TB] FAIL ntbl_offset got %h exp 000", vram_offset_o); end
    n_checks++; if (vram_data_o !== 8'h12) begin n_fail++; $display("[TB] FAIL ntbl_data got %h exp 12", vram_data_o); end
    tick();
  endtask

  task automatic test_reset_mid();
    drawing_next_i = 1'b1;
    in_vblank_i    = 1'b0;
    do_write(12'h210, 8'h01);
    do_write(12'h211, 8'h02);
    do_write(12'h212, 8'h03);
    n_checks++; if (pending_o !== 4'd3) begin n_fail++; $display("[TB] FAIL mid_pending_pre got %0d exp 3", pending_o); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drawing_next_i = 1'b0;
    n_checks++; if (pending_o !== 4'd0) begin n_fail++; $display("[TB] FAIL mid_pending got %0d exp 0", pending_o); end
    n_checks++; if (vram_data_o !== 8'h00) begin n_fail++; $display("[TB] FAIL mid_data got %h exp 00", vram_data_o); end
    n_checks++; if (select_o !== 5'b0) begin n_fail++; $display("[TB] FAIL mid_sel got %b exp 00000", select_o); end
    n_checks++; if (wr_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_ready got %0b exp 1", wr_ready_o); end
    n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_overflow got %0b exp 0", overflow_o); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (vram_wen_o !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_wen cycle %0d got %0b exp 0", i, vram_wen_o); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_txbl_latency();
    test_obm_vblank();
    test_order_blocking();
    test_overflow();
    test_invalid_region();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
